// File: rtl/pid_motor_io_pkg.sv
// Shared definitions for pid_motor_io: quadrature step codes and the
// saturation / magnitude helpers used by the error and power paths.
package pid_motor_io_pkg;

    localparam logic [1:0] STEP_NONE = 2'b00;
    localparam logic [1:0] STEP_INC  = 2'b01;
    localparam logic [1:0] STEP_DEC  = 2'b10;
    localparam logic [1:0] STEP_ILL  = 2'b11;

    // Encoder state is {a,b}; 00->01->11->10->00 counts up.
    function automatic logic [1:0] gray_step(input logic [1:0] prev, input logic [1:0] curr);
        logic [1:0] step;
        case ({prev, curr})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: step = STEP_INC;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: step = STEP_DEC;
            4'b0000, 4'b0101, 4'b1111, 4'b1010: step = STEP_NONE;
            default:                            step = STEP_ILL;
        endcase
        return step;
    endfunction

    // Clamp a sign-extended difference into the signed range of ew bits.
    function automatic logic signed [63:0] sat_ew(input logic signed [63:0] diff, input int ew);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ew - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (ew - 1));
        if (diff > hi) begin
            return hi;
        end else if (diff < lo) begin
            return lo;
        end else begin
            return diff;
        end
    endfunction

    // |m_k|, with the most negative code folded onto the largest magnitude.
    function automatic logic signed [63:0] abs_clamp(input logic signed [63:0] m_k, input int ow);
        logic signed [63:0] hi;
        logic signed [63:0] mag;
        hi  = (64'sd1 <<< (ow - 1)) - 64'sd1;
        mag = (m_k < 64'sd0) ? -m_k : m_k;
        if (mag > hi) begin
            return hi;
        end else begin
            return mag;
        end
    endfunction

endpackage

// File: rtl/pid_motor_io_if.sv
// Time-multiplexed link between the PID core (master) and the plant-side I/O block (slave).
interface pid_motor_io_if #(
    parameter int aw = 1,
    parameter int ow = 12,
    parameter int ew = 24
) ();
    logic          ce;
    logic [aw-1:0] a;
    logic [ow-1:0] m_k;
    logic [ew-1:0] error;

    modport master (output ce, output a, output m_k, input error);
    modport slave  (input ce, input a, input m_k, output error);
endinterface

// File: rtl/pid_motor_io_quad_decoder.sv
// One channel of x4 quadrature decoding: synchronizer, step decode,
// wrapping position counter and sticky illegal-transition flag.
module quad_decoder
    import pid_motor_io_pkg::*;
#(
    parameter int ew = 24
) (
    input  logic          clk_pid,
    input  logic          reset,
    input  logic          enc_a,
    input  logic          enc_b,
    output logic [ew-1:0] position,
    output logic          fault
);

    logic [1:0] meta_r;
    logic [1:0] sync_r;
    logic [1:0] prev_r;
    logic [1:0] step_s;

    // Two-flop synchronizer followed by the previous-state register.
    always_ff @(posedge clk_pid or posedge reset) begin
        if (reset) begin
            meta_r <= 2'b00;
            sync_r <= 2'b00;
            prev_r <= 2'b00;
        end else begin
            meta_r <= {enc_a, enc_b};
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    always_comb begin
        step_s = gray_step(prev_r, sync_r);
    end

    // An illegal double-bit change leaves the position untouched.
    always_ff @(posedge clk_pid or posedge reset) begin
        if (reset) begin
            position <= {ew{1'b0}};
            fault    <= 1'b0;
        end else begin
            case (step_s)
                STEP_INC: position <= position + ew'(1'b1);
                STEP_DEC: position <= position - ew'(1'b1);
                STEP_ILL: fault    <= 1'b1;
                default:  position <= position;
            endcase
        end
    end

endmodule

// File: rtl/pid_motor_io.sv
// Plant-side I/O for the multiplexed PID: position error mux, power capture
// and sign-magnitude PWM. Optional output watchdog: PID_MOTOR_IO_WATCHDOG_EN.
module pid_motor_io
    import pid_motor_io_pkg::*;
#(
    parameter int aw        = 1,
    parameter int ow        = 12,
    parameter int ew        = 24,
    parameter int wd_cycles = 4096
) (
    input  logic                    clk_pid,
    input  logic                    reset,
    pid_motor_io_if.slave           pid,
    input  logic [(2**aw)*ew-1:0]   setpoint,
    input  logic [(2**aw)-1:0]      enc_a,
    input  logic [(2**aw)-1:0]      enc_b,
    output logic [(2**aw)-1:0]      pwm_out,
    output logic [(2**aw)-1:0]      dir_out,
    output logic [(2**aw)-1:0]      enc_fault
);

    localparam int an = 2**aw;
    localparam int mw = ow - 1;

    if ((aw < 1) || (ow < 2) || (ew < 2) || (wd_cycles < 1)) begin : g_cfg_bad
        $error("pid_motor_io: invalid parameter set");
    end

    logic [ew-1:0]        position_s [an];
    logic [ew-1:0]        sp_sel_s;
    logic [ew-1:0]        pos_sel_s;
    logic signed [ew:0]   diff_s;
    logic [mw-1:0]        shadow_mag_r [an];
    logic [an-1:0]        shadow_dir_r;
    logic [mw-1:0]        load_mag_s [an];
    logic [mw-1:0]        duty_r [an];
    logic [mw-1:0]        cnt_r;
    logic                 wrap_s;

    for (genvar gi = 0; gi < an; gi++) begin : g_dec
        quad_decoder #(.ew(ew)) u_dec (
            .clk_pid  (clk_pid),
            .reset    (reset),
            .enc_a    (enc_a[gi]),
            .enc_b    (enc_b[gi]),
            .position (position_s[gi]),
            .fault    (enc_fault[gi])
        );
    end

    // ew+1 bits so the difference of two ew-bit values cannot overflow.
    always_comb begin
        sp_sel_s  = setpoint[pid.a*ew +: ew];
        pos_sel_s = position_s[pid.a];
        diff_s    = $signed({sp_sel_s[ew-1], sp_sel_s}) - $signed({pos_sel_s[ew-1], pos_sel_s});
    end

    always_ff @(posedge clk_pid or posedge reset) begin
        if (reset) begin
            pid.error <= {ew{1'b0}};
        end else begin
            pid.error <= ew'(sat_ew(64'(diff_s), ew));
        end
    end

    // Shadow registers take the strobed power word for the addressed channel only.
    always_ff @(posedge clk_pid or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < an; i++) begin
                shadow_mag_r[i] <= {mw{1'b0}};
            end
            shadow_dir_r <= {an{1'b0}};
        end else if (pid.ce) begin
            shadow_mag_r[pid.a] <= mw'(abs_clamp(64'($signed(pid.m_k)), ow));
            shadow_dir_r[pid.a] <= pid.m_k[ow-1];
        end else begin
            shadow_dir_r <= shadow_dir_r;
        end
    end

`ifdef PID_MOTOR_IO_WATCHDOG_EN
    localparam int wdw = $clog2(wd_cycles + 1);
    localparam logic [wdw-1:0] wd_max = wdw'(wd_cycles);

    logic [wdw-1:0] wd_cnt_r [an];

    // Per-channel silence counter; a saturated channel is forced to zero duty.
    always_ff @(posedge clk_pid or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < an; i++) begin
                wd_cnt_r[i] <= {wdw{1'b0}};
            end
        end else begin
            for (int i = 0; i < an; i++) begin
                if (pid.ce && (pid.a == aw'(i))) begin
                    wd_cnt_r[i] <= {wdw{1'b0}};
                end else if (wd_cnt_r[i] != wd_max) begin
                    wd_cnt_r[i] <= wd_cnt_r[i] + wdw'(1'b1);
                end else begin
                    wd_cnt_r[i] <= wd_cnt_r[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < an; i++) begin
            if (wd_cnt_r[i] == wd_max) begin
                load_mag_s[i] = {mw{1'b0}};
            end else begin
                load_mag_s[i] = shadow_mag_r[i];
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < an; i++) begin
            load_mag_s[i] = shadow_mag_r[i];
        end
    end
`endif

    assign wrap_s = &cnt_r;

    // Duty and direction only change at the period boundary.
    always_ff @(posedge clk_pid or posedge reset) begin
        if (reset) begin
            cnt_r   <= {mw{1'b0}};
            dir_out <= {an{1'b0}};
            for (int i = 0; i < an; i++) begin
                duty_r[i] <= {mw{1'b0}};
            end
        end else begin
            cnt_r <= cnt_r + mw'(1'b1);
            if (wrap_s) begin
                dir_out <= shadow_dir_r;
                for (int i = 0; i < an; i++) begin
                    duty_r[i] <= load_mag_s[i];
                end
            end else begin
                dir_out <= dir_out;
            end
        end
    end

    always_ff @(posedge clk_pid or posedge reset) begin
        if (reset) begin
            pwm_out <= {an{1'b0}};
        end else begin
            for (int i = 0; i < an; i++) begin
                pwm_out[i] <= (cnt_r < duty_r[i]);
            end
        end
    end

endmodule

// File: tb/tb_pid_motor_io.sv
// Directed self-checking bench for pid_motor_io (aw=1, ow=12, ew=24) with a
// scoreboard queue of expected values; watchdog checks follow PID_MOTOR_IO_WATCHDOG_EN.
module tb_pid_motor_io;

    localparam int AW = 1;
    localparam int OW = 12;
    localparam int EW = 24;
    localparam int AN = 2;
`ifdef PID_MOTOR_IO_WATCHDOG_EN
    localparam int WD_ON = 1;
`else
    localparam int WD_ON = 0;
`endif

    logic               clk_pid = 1'b0;
    logic               reset;
    logic [AN*EW-1:0]   setpoint;
    logic [AN-1:0]      enc_a;
    logic [AN-1:0]      enc_b;
    logic [AN-1:0]      pwm_out;
    logic [AN-1:0]      dir_out;
    logic [AN-1:0]      enc_fault;

    pid_motor_io_if #(.aw(AW), .ow(OW), .ew(EW)) pif ();

    pid_motor_io #(.aw(AW), .ow(OW), .ew(EW), .wd_cycles(4096)) dut (
        .clk_pid   (clk_pid),
        .reset     (reset),
        .pid       (pif),
        .setpoint  (setpoint),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .pwm_out   (pwm_out),
        .dir_out   (dir_out),
        .enc_fault (enc_fault)
    );

    always #5 clk_pid = ~clk_pid;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t          sb_q[$];
    int            n_asserts = 0;
    int            n_fail    = 0;
    int            q_idx [AN];
    logic [OW-1:0] mv [AN];
    logic [AW-1:0] a_home;

    task automatic sb_push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        n_asserts++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic set_pins(input int ch);
        logic [1:0] g;
        case (q_idx[ch])
            0:       g = 2'b00;
            1:       g = 2'b01;
            2:       g = 2'b11;
            default: g = 2'b10;
        endcase
        enc_a[ch] = g[1];
        enc_b[ch] = g[0];
    endtask

    task automatic step(input int ch, input bit fwd);
        q_idx[ch] = fwd ? (q_idx[ch] + 1) % 4 : (q_idx[ch] + 3) % 4;
        set_pins(ch);
        repeat (2) @(negedge clk_pid);
    endtask

    task automatic pulse_ce(input int ch, input logic [OW-1:0] val);
        mv[ch]  = val;
        pif.a   = AW'(ch);
        pif.m_k = val;
        pif.ce  = 1'b1;
        @(negedge clk_pid);
        pif.ce  = 1'b0;
        pif.a   = a_home;
    endtask

    // Re-strobes the current power words mid-window so watchdogs of kept channels stay clear.
    task automatic drive_refresh(input int c, input logic [AN-1:0] keep);
        if (c == 1000) begin
            pif.a = 1'b0; pif.m_k = mv[0]; pif.ce = keep[0];
        end else if (c == 1001) begin
            pif.a = 1'b1; pif.m_k = mv[1]; pif.ce = keep[1];
        end else if (c == 1002) begin
            pif.ce = 1'b0; pif.a = a_home;
        end
    endtask

    task automatic measure(input logic [AN-1:0] keep, output int h0, output int h1);
        h0 = 0;
        h1 = 0;
        for (int c = 0; c < 2050; c++) begin
            @(negedge clk_pid);
            drive_refresh(c, keep);
        end
        for (int c = 0; c < 2048; c++) begin
            @(negedge clk_pid);
            h0 += int'(pwm_out[0]);
            h1 += int'(pwm_out[1]);
            drive_refresh(c, keep);
        end
    endtask

    initial begin
        int  h0;
        int  h1;
        bit  found;

        reset    = 1'b1;
        pif.ce   = 1'b0;
        pif.a    = 1'b0;
        pif.m_k  = '0;
        setpoint = '0;
        enc_a    = '0;
        enc_b    = '0;
        a_home   = 1'b0;
        for (int i = 0; i < AN; i++) begin
            q_idx[i] = 0;
            mv[i]    = '0;
        end

        // Reset state.
        repeat (3) @(negedge clk_pid);
        sb_push("rst_error", 32'h0);     sb_check(32'(pif.error));
        sb_push("rst_pwm", 32'h0);       sb_check(32'(pwm_out));
        sb_push("rst_dir", 32'h0);       sb_check(32'(dir_out));
        sb_push("rst_fault", 32'h0);     sb_check(32'(enc_fault));
        reset = 1'b0;
        repeat (2) @(negedge clk_pid);

        // Forward counting on channel 0 with setpoint 0.
        for (int i = 0; i < 4; i++) step(0, 1'b1);
        repeat (2) @(negedge clk_pid);
        sb_push("err_pos4", 32'h00FFFFFC);  sb_check(32'(pif.error));
        for (int i = 0; i < 4; i++) step(0, 1'b1);
        repeat (2) @(negedge clk_pid);
        sb_push("err_pos8", 32'h00FFFFF8);  sb_check(32'(pif.error));

        // Negative saturation: -2^23 - 8 clamps to -2^23.
        setpoint[EW-1:0] = 24'h800000;
        repeat (2) @(negedge clk_pid);
        sb_push("err_sat_neg", 32'h00800000);  sb_check(32'(pif.error));
        setpoint[EW-1:0] = 24'h000000;

        // Channel 1: two reverse steps, positive saturation and a plain difference.
        setpoint[2*EW-1:EW] = 24'h7FFFFF;
        step(1, 1'b0);
        step(1, 1'b0);
        a_home = 1'b1;
        pif.a  = 1'b1;
        repeat (3) @(negedge clk_pid);
        sb_push("err_sat_pos", 32'h007FFFFF);  sb_check(32'(pif.error));
        setpoint[2*EW-1:EW] = 24'h000010;
        repeat (2) @(negedge clk_pid);
        sb_push("err_ch1_diff", 32'h00000012);  sb_check(32'(pif.error));
        a_home = 1'b0;
        pif.a  = 1'b0;
        repeat (2) @(negedge clk_pid);

        // Illegal double transition on channel 0 (00 -> 11).
        enc_a[0] = 1'b1;
        enc_b[0] = 1'b1;
        q_idx[0] = 2;
        repeat (4) @(negedge clk_pid);
        sb_push("fault_set", 32'h1);            sb_check(32'(enc_fault));
        sb_push("err_after_ill", 32'h00FFFFF8); sb_check(32'(pif.error));
        step(0, 1'b1);
        repeat (2) @(negedge clk_pid);
        sb_push("err_after_legal", 32'h00FFFFF7); sb_check(32'(pif.error));
        sb_push("fault_sticky", 32'h1);           sb_check(32'(enc_fault));

        // PWM: half duty on channel 1.
        pulse_ce(1, 12'd1024);
        measure(2'b11, h0, h1);
        sb_push("pwm1_half", 32'd1024);  sb_check(32'(h1));
        sb_push("pwm0_idle", 32'd0);     sb_check(32'(h0));
        sb_push("dir_pos", 32'h0);       sb_check(32'(dir_out));

        // Most negative power word clamps to full duty, reverse direction.
        pulse_ce(0, 12'h800);
        measure(2'b11, h0, h1);
        sb_push("pwm0_max", 32'd2047);   sb_check(32'(h0));
        sb_push("pwm1_keep", 32'd1024);  sb_check(32'(h1));
        sb_push("dir_neg", 32'h1);       sb_check(32'(dir_out));

        // Zero power gives a constant low output.
        pulse_ce(0, 12'h000);
        measure(2'b11, h0, h1);
        sb_push("pwm0_zero", 32'd0);     sb_check(32'(h0));
        sb_push("dir_zero", 32'h0);      sb_check(32'(dir_out));

        // No strobes for longer than the watchdog timeout.
        repeat (4200) @(negedge clk_pid);
        measure(2'b00, h0, h1);
        sb_push("pwm1_silent", (WD_ON != 0) ? 32'd0 : 32'd1024);  sb_check(32'(h1));

        // One strobe revives channel 0 only.
        pulse_ce(0, 12'd500);
        measure(2'b01, h0, h1);
        sb_push("pwm0_resume", 32'd500);  sb_check(32'(h0));
        sb_push("pwm1_still", (WD_ON != 0) ? 32'd0 : 32'd1024);  sb_check(32'(h1));

        // Reset in the high phase of channel 0.
        found = 1'b0;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk_pid);
            if (pwm_out[0]) begin
                found = 1'b1;
                break;
            end
        end
        sb_push("pwm0_high_seen", 32'h1);  sb_check(32'(found));
        #2;
        reset = 1'b1;
        #1;
        sb_push("mid_rst_pwm", 32'h0);     sb_check(32'(pwm_out));
        sb_push("mid_rst_dir", 32'h0);     sb_check(32'(dir_out));
        sb_push("mid_rst_fault", 32'h0);   sb_check(32'(enc_fault));
        sb_push("mid_rst_error", 32'h0);   sb_check(32'(pif.error));
        enc_a = '0;
        enc_b = '0;
        @(negedge clk_pid);
        reset = 1'b0;
        repeat (4) @(negedge clk_pid);
        sb_push("post_rst_fault", 32'h0);  sb_check(32'(enc_fault));
        sb_push("post_rst_error", 32'h0);  sb_check(32'(pif.error));

        if (sb_q.size() != 0) begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/pid_motor_io.md
Name: pid_motor_io

Overview:
- Plant-side counterpart of the multiplexed PID controller.
- Produces the signed per-channel position error the controller samples, and consumes its time-multiplexed motor-power word.
- Per channel: x4 quadrature position counter, setpoint subtraction with saturation, and a sign-magnitude PWM driver.
- Sits between the PID core and motor H-bridge/encoder pins; one instance serves all 2^aw channels.

Parameters:
- aw, 1, address width; an = 2^aw channels.
- ow, 12, width of signed motor-power input; PWM resolution = ow-1 bits.
- ew, 24, width of signed error output and of position counters.
- wd_cycles, 4096, watchdog timeout in clk_pid cycles (used only with the optional feature).

Ports:
- clk_pid  in  1  PID/system clock.
- reset  in  1  reset, asynchronous, active-high.
- ce  in  1  PID data strobe; the motor-power input is valid for channel a when high.
- a  in  aw  channel address currently served by the PID.
- m_k  in  ow  signed motor power for channel a.
- setpoint  in  an*ew  flattened signed setpoints; channel i occupies bits [i*ew +: ew].
- error  out  ew  signed error for channel a, registered.
- enc_a, enc_b  in  an  raw asynchronous quadrature inputs.
- pwm_out  out  an  PWM magnitude outputs.
- dir_out  out  an  direction: 1 = negative power.
- enc_fault  out  an  sticky illegal-transition flag per channel.

Behaviour:
- Reset values: error=0, pwm_out=0, dir_out=0, enc_fault=0, all positions=0, all duty/dir shadows=0, PWM counter=0.
- Encoder front end:
  - Two-flop synchronizer per input, then a previous-state register.
  - Gray step 00→01→11→10→00 is +1; the reverse sequence is -1.
  - No change: hold.
  - Both bits changed in one cycle: illegal. Position holds and enc_fault[i] is set; it clears only on reset.
  - Position wraps modulo 2^ew (two's complement).
  - Latency from pin edge to position update: 3 clk.
- Error path, every cycle:
  - diff = sext(setpoint[a]) - sext(position[a]) computed in ew+1 bits.
  - Saturate to [-2^(ew-1), 2^(ew-1)-1], register into error.
  - Error is therefore valid 1 clk after a changes. The PID samples at least 1024 clk after an address change, so this margin is sufficient.
  - Setpoint is sampled every cycle; it is not latched.
- Power capture, on ce=1:
  - shadow_dir[a] ← m_k[ow-1].
  - shadow_mag[a] ← |m_k|.
  - m_k = -2^(ow-1) clamps the magnitude to 2^(ow-1)-1.
  - Only the addressed channel updates.
- PWM:
  - One shared free-running counter cnt of ow-1 bits, period 2^(ow-1) clk.
  - At cnt wrap (cnt = all ones → 0), each channel loads duty[i] ← shadow_mag[i] and dir_out[i] ← shadow_dir[i]. There are no mid-period duty or direction changes.
  - pwm_out[i] = (cnt < duty[i]), registered (1 clk latency).
  - duty=0 gives a constant low output; the maximum duty gives high for all but one cycle of the period.
- Simultaneous events:
  - ce coinciding with a wrap: the wrap loads the old shadow value; the new shadow is used at the next wrap.
  - Encoder step coinciding with an error computation: the error uses the pre-update position.
- Reset mid-operation: all state returns to reset values immediately; pwm_out drops low asynchronously.

Optional Feature:
- Macro: PID_MOTOR_IO_WATCHDOG_EN.
- When defined:
  - Each channel has a counter of clog2(wd_cycles+1) bits, cleared on ce for that channel and saturating at wd_cycles.
  - While saturated, duty loads 0 at wrap, so pwm_out stays low; dir is unchanged.
  - The first subsequent ce restores normal loading at the next wrap.
- When not defined: no counters; the last captured power persists indefinitely.

Decomposition:
- Shared package pid_motor_io_pkg holds:
  - the Gray-step decode constants: step codes +1/-1/0/illegal;
  - function sat_ew(diff), the saturation helper;
  - function abs_clamp(m_k), the magnitude clamp.
- One sub-module, quad_decoder: synchronizer, step decode, position counter and fault flag for one channel. It is instantiated an times in a generate loop.
- Mux, subtract/saturate, shadow registers, PWM counter/comparators and the watchdog stay in the top module.

Test Plan (aw=1, ow=12, ew=24):
- setpoint0=0, 8 forward Gray steps on channel 0, a=0 → position0=8; error=0xFFFFF8 within 4 clk of the last step.
- ce with a=1, m_k=+1024 → after the next wrap, pwm_out[1] is high exactly 1024 of 2048 cycles and dir_out[1]=0; pwm_out[0] is unaffected.
- ce with a=0, m_k=-2048 (0x800) → dir_out[0]=1 and pwm_out[0] high 2047 of 2048 cycles after the wrap; m_k=0 → constant low.
- setpoint1=0x7FFFFF, position1=-2 (2 reverse steps), a=1 → error=0x7FFFFF (saturated, not wrapped).
- enc_a[0] and enc_b[0] toggled in the same cycle → position0 unchanged, enc_fault[0]=1 until reset; a legal step afterwards still counts.
- Watchdog on: ce stopped for 4096 clk → pwm_out low from the next wrap; one ce with a=0, m_k=500 → 500/2048 duty resumes at the following wrap. Assert reset mid-period → all outputs 0 immediately.
